// File: rtl/tdm_demux4_rx.sv
// -----------------------------------------------------------------------------
// tdm_demux4_rx
//
// Serial receive end of the 4-channel time-division link. The transmitter
// sends frames of the form
//     SYNC_WORD (8 bits) | ch0 | ch1 | ch2 | ch3 (WIDTH bits each) [| P]
// all MSB first. This block hunts for the sync word in the incoming bit
// stream, decodes the four channel words and commits them together once per
// frame. It then checks the sync word in front of every following frame to
// track lock. A small flywheel tolerates up to MISS_LIMIT-1 consecutive bad
// sync words before it gives up alignment and returns to hunting.
//
// Parameters:
//   WIDTH       bits per channel word (1..16)
//   SYNC_WORD   8-bit frame alignment word (nonzero)
//   MISS_LIMIT  consecutive bad sync words that drop lock (1..7)
//
// Optional build macro:
//   TDM_PARITY_EN  when defined, an even-parity bit P follows ch3. The commit
//                  moves to the edge that accepts P. A frame whose parity
//                  fails is not committed and pulses parity_err instead.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   din          serial data bit, MSB first
//   din_valid    din is accepted only on edges where this is 1
//   ch0..ch3     decoded channel words, registered, held between commits
//   frame_valid  one-cycle pulse in the cycle after ch0..ch3 update
//   locked       alignment confirmed by at least one repeated sync word
//   parity_err   (TDM_PARITY_EN only) one-cycle pulse on a parity failure
// -----------------------------------------------------------------------------
module tdm_demux4_rx #(
    parameter int unsigned WIDTH      = 8,
    parameter logic [7:0]  SYNC_WORD  = 8'hA5,
    parameter int unsigned MISS_LIMIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             frame_valid,
    output logic             locked
`ifdef TDM_PARITY_EN
   ,output logic             parity_err
`endif
);

    // Number of slot words that must be buffered before the commit. Without
    // parity, slot 3 is taken straight from the assembly path on the commit
    // edge, so only slots 0..2 need storage.
`ifdef TDM_PARITY_EN
    localparam int NBUF = 4;
`else
    localparam int NBUF = 3;
`endif

    // The assembly shift register only has to remember WIDTH-1 bits: the
    // current bit completes the word combinationally.
    localparam int         SW       = (WIDTH > 1) ? WIDTH - 1 : 1;
    localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);
    localparam logic [2:0] MISS_LIM = 3'(MISS_LIMIT);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_DATA   = 2'd1,
        S_CHECK  = 2'd2,
        S_PARITY = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [6:0]       r_sync_sr;     // last 7 accepted bits (HUNT and CHECK)
    logic [3:0]       r_fill;        // bits seen in HUNT, saturates at 8
    logic [2:0]       r_miss;        // consecutive bad sync words
    logic [1:0]       r_slot;        // channel slot being assembled
    logic [4:0]       r_bit_cnt;     // bit within slot, or within sync in CHECK
    logic [SW-1:0]    r_shift;       // slot assembly register
    logic [WIDTH-1:0] r_ch0;
    logic [WIDTH-1:0] r_ch1;
    logic [WIDTH-1:0] r_ch2;
    logic [WIDTH-1:0] r_ch3;
    logic             r_frame_valid;
    logic             r_locked;
`ifdef TDM_PARITY_EN
    logic             r_parity;      // running XOR of the frame's data bits
    logic             r_parity_err;
`endif

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [7:0]       w_sync_next;   // sync window including the current bit
    logic [WIDTH-1:0] w_word;        // slot word including the current bit
    logic             w_word_done;   // this edge completes a slot word
    logic [WIDTH-1:0] w_buf [0:NBUF-1];

    assign w_sync_next = {r_sync_sr, din};
    assign w_word_done = (r_state == S_DATA) && din_valid && (r_bit_cnt == LAST_BIT);

    generate
        if (WIDTH > 1) begin : g_word_wide
            assign w_word = {r_shift, din};
        end else begin : g_word_narrow
            assign w_word = din;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Slot buffers: each one captures its word on the edge that completes
    // that slot, so all of ch0..ch3 can be loaded on a single commit edge.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NBUF; gi++) begin : g_slot
            logic [WIDTH-1:0] r_word;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_word <= '0;
                end else if (w_word_done && (r_slot == 2'(gi))) begin
                    r_word <= w_word;
                end
            end

            assign w_buf[gi] = r_word;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Framing state machine with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_HUNT;
            r_sync_sr     <= '0;
            r_fill        <= '0;
            r_miss        <= '0;
            r_slot        <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_ch0         <= '0;
            r_ch1         <= '0;
            r_ch2         <= '0;
            r_ch3         <= '0;
            r_frame_valid <= 1'b0;
            r_locked      <= 1'b0;
`ifdef TDM_PARITY_EN
            r_parity      <= 1'b0;
            r_parity_err  <= 1'b0;
`endif
        end else begin
            // Pulses last one cycle regardless of din_valid.
            r_frame_valid <= 1'b0;
`ifdef TDM_PARITY_EN
            r_parity_err  <= 1'b0;
`endif
            if (din_valid) begin
                case (r_state)
                    S_HUNT: begin
                        r_sync_sr <= w_sync_next[6:0];
                        if (r_fill != 4'd8) begin
                            r_fill <= r_fill + 4'd1;
                        end
                        // fill >= 7 before this bit means the window is full
                        // once the current bit is counted.
                        if ((r_fill >= 4'd7) && (w_sync_next == SYNC_WORD)) begin
                            r_state   <= S_DATA;
                            r_slot    <= '0;
                            r_bit_cnt <= '0;
`ifdef TDM_PARITY_EN
                            r_parity  <= 1'b0;
`endif
                        end
                    end

                    S_DATA: begin
                        r_shift <= w_word[SW-1:0];
`ifdef TDM_PARITY_EN
                        r_parity <= r_parity ^ din;
`endif
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_slot    <= r_slot + 2'd1;
                            if (r_slot == 2'd3) begin
`ifdef TDM_PARITY_EN
                                r_state <= S_PARITY;
`else
                                // Commit: ch3 comes straight from the
                                // assembly path, including this edge's bit.
                                r_ch0         <= w_buf[0];
                                r_ch1         <= w_buf[1];
                                r_ch2         <= w_buf[2];
                                r_ch3         <= w_word;
                                r_frame_valid <= 1'b1;
                                r_state       <= S_CHECK;
`endif
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end

`ifdef TDM_PARITY_EN
                    S_PARITY: begin
                        // Even parity over all data bits plus P.
                        if ((r_parity ^ din) == 1'b0) begin
                            r_ch0         <= w_buf[0];
                            r_ch1         <= w_buf[1];
                            r_ch2         <= w_buf[2];
                            r_ch3         <= w_buf[3];
                            r_frame_valid <= 1'b1;
                        end else begin
                            r_parity_err  <= 1'b1;
                        end
                        r_state   <= S_CHECK;
                        r_bit_cnt <= '0;
                    end
`endif

                    S_CHECK: begin
                        r_sync_sr <= w_sync_next[6:0];
                        if (r_bit_cnt == 5'd7) begin
                            r_bit_cnt <= '0;
                            if (w_sync_next == SYNC_WORD) begin
                                r_miss   <= '0;
                                r_locked <= 1'b1;
                                r_state  <= S_DATA;
                                r_slot   <= '0;
`ifdef TDM_PARITY_EN
                                r_parity <= 1'b0;
`endif
                            end else if ((r_miss + 3'd1) == MISS_LIM) begin
                                // Too many misses in a row: alignment is lost,
                                // restart the hunt with an empty window.
                                r_locked <= 1'b0;
                                r_miss   <= '0;
                                r_fill   <= '0;
                                r_state  <= S_HUNT;
                            end else begin
                                // Flywheel: assume the frame is still aligned
                                // and keep decoding.
                                r_miss   <= r_miss + 3'd1;
                                r_state  <= S_DATA;
                                r_slot   <= '0;
`ifdef TDM_PARITY_EN
                                r_parity <= 1'b0;
`endif
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end

                    default: begin
                        r_state <= S_HUNT;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ch0         = r_ch0;
    assign ch1         = r_ch1;
    assign ch2         = r_ch2;
    assign ch3         = r_ch3;
    assign frame_valid = r_frame_valid;
    assign locked      = r_locked;
`ifdef TDM_PARITY_EN
    assign parity_err  = r_parity_err;
`endif

endmodule

// File: tb/tb_tdm_demux4_rx.sv
// -----------------------------------------------------------------------------
// Testbench for tdm_demux4_rx. Stimulus is a queue of {valid, bit} entries
// built from frame descriptions; a frame-level reference model tracks the
// receiver's alignment from the accepted bit history and predicts every
// output after every clock edge.
// -----------------------------------------------------------------------------
module tb_tdm_demux4_rx;

    localparam int         W     = 8;
    localparam logic [7:0] SYNC  = 8'hA5;
    localparam int         LIMIT = 2;
`ifdef TDM_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int BODY = 4 * W + PAR;
    localparam int FLEN = 8 + BODY;
    localparam int OW   = 4 * W + 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         din = 1'b0;
    logic         din_valid = 1'b0;
    logic [W-1:0] ch0, ch1, ch2, ch3;
    logic         frame_valid;
    logic         locked;
    logic         perr_obs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tdm_demux4_rx #(
        .WIDTH      (W),
        .SYNC_WORD  (SYNC),
        .MISS_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .din_valid   (din_valid),
        .ch0         (ch0),
        .ch1         (ch1),
        .ch2         (ch2),
        .ch3         (ch3),
        .frame_valid (frame_valid),
        .locked      (locked)
`ifdef TDM_PARITY_EN
       ,.parity_err  (perr_obs)
`endif
    );

`ifndef TDM_PARITY_EN
    assign perr_obs = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Reference model: alignment mode, position inside the aligned frame,
    // and the history of accepted bits from which words are sliced.
    // ------------------------------------------------------------------
    int           m_mode;     // 0 = searching, 1 = aligned
    int           m_fill;
    int           m_pos;      // accepted bits since the last sync word ended
    int           m_miss;
    bit           m_hist[$];
    logic [W-1:0] e_ch [4];
    logic         e_fv, e_lock, e_perr;

    logic [1:0]   tx[$];      // {valid, bit}
    int           gap_rate = 0;

    function automatic void model_reset();
        m_mode = 0; m_fill = 0; m_pos = 0; m_miss = 0;
        m_hist.delete();
        for (int k = 0; k < 4; k++) e_ch[k] = '0;
        e_fv = 1'b0; e_lock = 1'b0; e_perr = 1'b0;
    endfunction

    function automatic logic [7:0] m_last8();
        logic [7:0] v;
        int n;
        v = '0;
        n = m_hist.size();
        for (int k = 0; k < 8; k++) v = {v[6:0], m_hist[n - 8 + k]};
        return v;
    endfunction

    function automatic void model_edge(input logic b, input logic v);
        logic [W-1:0] wd [4];
        int base;
        bit p;
        e_fv = 1'b0;
        e_perr = 1'b0;
        if (v !== 1'b1) return;
        m_hist.push_back(b);
        if (m_hist.size() > 200) void'(m_hist.pop_front());
        if (m_mode == 0) begin
            m_fill++;
            if (m_fill >= 8 && m_last8() == SYNC) begin
                m_mode = 1;
                m_pos = 0;
            end
        end else begin
            m_pos++;
            if (m_pos == BODY) begin
                base = m_hist.size() - BODY;
                p = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    wd[k] = '0;
                    for (int j = 0; j < W; j++) wd[k] = {wd[k][W-2:0], m_hist[base + k*W + j]};
                end
                for (int j = 0; j < BODY; j++) p ^= m_hist[base + j];
                if (PAR == 0 || p == 1'b0) begin
                    for (int k = 0; k < 4; k++) e_ch[k] = wd[k];
                    e_fv = 1'b1;
                end else begin
                    e_perr = 1'b1;
                end
            end else if (m_pos == BODY + 8) begin
                if (m_last8() == SYNC) begin
                    m_miss = 0;
                    e_lock = 1'b1;
                    m_pos = 0;
                end else begin
                    m_miss++;
                    if (m_miss == LIMIT) begin
                        e_lock = 1'b0;
                        m_miss = 0;
                        m_mode = 0;
                        m_fill = 0;
                    end else begin
                        m_pos = 0;
                    end
                end
            end
        end
    endfunction

    function automatic logic [OW-1:0] obs();
        return {ch0, ch1, ch2, ch3, frame_valid, locked, perr_obs};
    endfunction

    function automatic logic [OW-1:0] expv();
        return {e_ch[0], e_ch[1], e_ch[2], e_ch[3], e_fv, e_lock, e_perr};
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking)
    // ------------------------------------------------------------------
    task automatic drive(input logic b, input logic v);
        din = b;
        din_valid = v;
        @(posedge clk);
        model_edge(b, v);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
    endtask

    function automatic void add_gap(input int n);
        for (int k = 0; k < n; k++) tx.push_back({1'b0, 1'($urandom_range(0, 1))});
    endfunction

    function automatic void add_bits(input logic [15:0] val, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            if (gap_rate > 0 && $urandom_range(0, gap_rate - 1) == 0) add_gap(1);
            tx.push_back({1'b1, val[k]});
        end
    endfunction

    function automatic void add_frame(input logic [7:0] s, input logic [W-1:0] c0,
                                      input logic [W-1:0] c1, input logic [W-1:0] c2,
                                      input logic [W-1:0] c3, input logic bad_par);
        logic p;
        add_bits(16'(s), 8);
        add_bits(16'(c0), W);
        add_bits(16'(c1), W);
        add_bits(16'(c2), W);
        add_bits(16'(c3), W);
        p = (^{c0, c1, c2, c3}) ^ bad_par;
        if (PAR != 0) add_bits(16'(p), 1);
    endfunction

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (obs() !== OW'(0)) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", obs(), OW'(0));
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reset_idle idx=%0d got=%h want=%h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_first_frame();
        int fv_idx = -1, fv_cnt = 0;
        tx.delete();
        add_frame(SYNC, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
        for (int i = 0; i < tx.size(); i++) begin
            drive(tx[i][0], tx[i][1]);
            if (frame_valid === 1'b1) begin fv_idx = i; fv_cnt++; end
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL first_frame idx=%0d got=%h want=%h", i, obs(), expv());
            end
        end
        checks++;
        if (fv_cnt != 1 || fv_idx != FLEN - 1) begin
            errors++;
            $display("FAIL first_frame_pulse got idx=%0d cnt=%0d want idx=%0d cnt=1", fv_idx, fv_cnt, FLEN - 1);
        end
        checks++;
        if ({ch0, ch1, ch2, ch3, locked} !== {32'h11223344, 1'b0}) begin
            errors++;
            $display("FAIL first_frame_words got=%h%h%h%h lock=%b want=11223344 lock=0", ch0, ch1, ch2, ch3, locked);
        end
    endtask

    task automatic test_lock();
        int fv_idx = -1, lock_idx = -1;
        tx.delete();
        add_frame(SYNC, 8'h55, 8'h66, 8'h77, 8'h88, 1'b0);
        for (int i = 0; i < tx.size(); i++) begin
            drive(tx[i][0], tx[i][1]);
            if (frame_valid === 1'b1) fv_idx = i;
            if (locked === 1'b1 && lock_idx < 0) lock_idx = i;
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL lock idx=%0d got=%h want=%h", i, obs(), expv());
            end
        end
        checks++;
        if (lock_idx != 7) begin
            errors++;
            $display("FAIL lock_edge got=%0d want=7", lock_idx);
        end
        checks++;
        if (fv_idx != FLEN - 1 || {ch0, ch1, ch2, ch3} !== 32'h55667788) begin
            errors++;
            $display("FAIL lock_words got idx=%0d %h%h%h%h want idx=%0d 55667788", fv_idx, ch0, ch1, ch2, ch3, FLEN - 1);
        end
    endtask

    task automatic test_junk_prefix();
        int fv_idx = -1, fv_cnt = 0;
        apply_reset();
        tx.delete();
        add_bits(16'b10110, 5);
        add_frame(SYNC, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
        for (int i = 0; i < tx.size(); i++) begin
            drive(tx[i][0], tx[i][1]);
            if (frame_valid === 1'b1) begin fv_idx = i; fv_cnt++; end
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL junk idx=%0d got=%h want=%h", i, obs(), expv());
            end
        end
        checks++;
        if (fv_cnt != 1 || fv_idx != 5 + FLEN - 1 || {ch0, ch1, ch2, ch3} !== 32'h11223344) begin
            errors++;
            $display("FAIL junk_frame got idx=%0d cnt=%0d %h%h%h%h want idx=%0d cnt=1 11223344",
                     fv_idx, fv_cnt, ch0, ch1, ch2, ch3, 5 + FLEN - 1);
        end
    endtask

    task automatic test_flywheel();
        logic lk[$];
        logic fv[$];
        int hunt_fv = 0;
        tx.delete();
        add_frame(SYNC,          W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0);
        add_frame(SYNC ^ 8'h01,  W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0);
        add_frame(SYNC,          W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0);
        add_frame(SYNC ^ 8'h01,  W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0);
        add_frame(SYNC ^ 8'h01,  '0, '0, '0, '0, 1'b0);
        add_frame(SYNC,          W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0);
        for (int i = 0; i < tx.size(); i++) begin
            drive(tx[i][0], tx[i][1]);
            lk.push_back(locked);
            fv.push_back(frame_valid);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL flywheel idx=%0d got=%h want=%h", i, obs(), expv());
            end
        end
        checks++;
        if (lk[FLEN + 7] !== 1'b1 || fv[2*FLEN - 1] !== 1'b1) begin
            errors++;
            $display("FAIL flywheel_single_miss got lock=%b fv=%b want lock=1 fv=1", lk[FLEN + 7], fv[2*FLEN - 1]);
        end
        checks++;
        if (lk[3*FLEN + 7] !== 1'b1) begin
            errors++;
            $display("FAIL flywheel_miss_cleared got lock=%b want 1", lk[3*FLEN + 7]);
        end
        checks++;
        if (lk[4*FLEN + 6] !== 1'b1 || lk[4*FLEN + 7] !== 1'b0) begin
            errors++;
            $display("FAIL flywheel_drop got lock=%b,%b want 1,0", lk[4*FLEN + 6], lk[4*FLEN + 7]);
        end
        for (int i = 4*FLEN + 8; i < 6*FLEN - 1; i++) if (fv[i] === 1'b1) hunt_fv++;
        checks++;
        if (hunt_fv != 0 || fv[6*FLEN - 1] !== 1'b1) begin
            errors++;
            $display("FAIL flywheel_rehunt got early=%0d final=%b want early=0 final=1", hunt_fv, fv[6*FLEN - 1]);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] c[4];
        int fv_idx = -1;
        for (int k = 0; k < 4; k++) c[k] = W'($urandom);
        tx.delete();
        add_bits(16'(SYNC), 8);
        add_bits(16'(c[0]), W);
        add_bits(16'(c[1]), W);
        add_bits(16'(c[2][7:4]), 4);
        add_gap(5);
        add_bits(16'(c[2][3:0]), 4);
        add_bits(16'(c[3]), W);
        if (PAR != 0) add_bits(16'(^{c[0], c[1], c[2], c[3]}), 1);
        for (int i = 0; i < tx.size(); i++) begin
            drive(tx[i][0], tx[i][1]);
            if (frame_valid === 1'b1) fv_idx = i;
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL stall idx=%0d got=%h want=%h", i, obs(), expv());
            end
        end
        checks++;
        if (fv_idx != FLEN - 1 + 5 || {ch0, ch1, ch2, ch3} !== {c[0], c[1], c[2], c[3]}) begin
            errors++;
            $display("FAIL stall_frame got idx=%0d %h%h%h%h want idx=%0d %h%h%h%h",
                     fv_idx, ch0, ch1, ch2, ch3, FLEN + 4, c[0], c[1], c[2], c[3]);
        end
    endtask

    task automatic test_reset_mid();
        int early_fv = 0, last_fv = 0;
        tx.delete();
        add_frame(SYNC, 8'h55, 8'h66, 8'h77, 8'h88, 1'b0);
        add_bits(16'(SYNC), 8);
        add_bits(16'h0055, 8);
        add_bits(16'b011, 3);
        for (int i = 0; i < tx.size(); i++) begin
            drive(tx[i][0], tx[i][1]);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reset_mid_pre idx=%0d got=%h want=%h", i, obs(), expv());
            end
        end
        checks++;
        if ({ch0, ch1, ch2, ch3} !== 32'h55667788) begin
            errors++;
            $display("FAIL reset_mid_before got=%h%h%h%h want=55667788", ch0, ch1, ch2, ch3);
        end
        reset = 1'b1;
        #2;
        model_reset();
        checks++;
        if (obs() !== OW'(0)) begin
            errors++;
            $display("FAIL reset_mid_async got=%h want=%h", obs(), OW'(0));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tx.delete();
        add_bits(16'b00110, 5);
        add_bits(16'h0077, 8);
        add_bits(16'h0088, 8);
        add_frame(SYNC, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0);
        for (int i = 0; i < tx.size(); i++) begin
            drive(tx[i][0], tx[i][1]);
            if (frame_valid === 1'b1) begin
                if (i == tx.size() - 1) last_fv = 1; else early_fv++;
            end
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reset_mid_post idx=%0d got=%h want=%h", i, obs(), expv());
            end
        end
        checks++;
        if (early_fv != 0 || last_fv != 1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_realign got early=%0d last=%0d lock=%b want early=0 last=1 lock=0",
                     early_fv, last_fv, locked);
        end
    endtask

`ifdef TDM_PARITY_EN
    task automatic test_parity();
        int pe_idx = -1, fv_cnt = 0;
        tx.delete();
        add_frame(SYNC, 8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
        add_frame(SYNC, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 1'b1);
        for (int i = 0; i < tx.size(); i++) begin
            drive(tx[i][0], tx[i][1]);
            if (perr_obs === 1'b1) pe_idx = i;
            if (frame_valid === 1'b1) fv_cnt++;
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL parity idx=%0d got=%h want=%h", i, obs(), expv());
            end
        end
        checks++;
        if (pe_idx != 2*FLEN - 1 || fv_cnt != 1 || {ch0, ch1, ch2, ch3} !== 32'h12345678) begin
            errors++;
            $display("FAIL parity_reject got pe=%0d fv=%0d %h%h%h%h want pe=%0d fv=1 12345678",
                     pe_idx, fv_cnt, ch0, ch1, ch2, ch3, 2*FLEN - 1);
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] s;
        int bi;
        tx.delete();
        gap_rate = 6;
        for (int f = 0; f < 40; f++) begin
            s = SYNC;
            if ($urandom_range(0, 6) == 0) begin
                bi = $urandom_range(0, 7);
                s[bi] = ~s[bi];
            end
            if ($urandom_range(0, 11) == 0) add_bits(16'($urandom_range(0, 1)), 1);
            add_frame(s, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                      1'($urandom_range(0, 4) == 0));
        end
        gap_rate = 0;
        for (int i = 0; i < tx.size(); i++) begin
            drive(tx[i][0], tx[i][1]);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random idx=%0d got=%h want=%h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_frame();
        test_lock();
        test_junk_prefix();
        test_flywheel();
        test_stall();
        test_reset_mid();
`ifdef TDM_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/tdm_demux4_rx.md
Name: tdm_demux4_rx

Overview:
- Serial receive end of the 4-channel time-division link. The transmit side selects 4 channel words in turn and serialises them behind a sync word.
- This block finds frame alignment in the incoming bit stream and tracks lock.
- It returns the 4 channel words as parallel registered outputs, updated once per frame.
- It sits between the serial line input (after synchronisation to clk) and the consumer logic for each channel.

Parameters:
WIDTH, 8, bits per channel word (1..16)
SYNC_WORD, 8'hA5, 8-bit frame alignment word; must be nonzero
MISS_LIMIT, 2, consecutive bad sync words that drop lock (1..7)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
din  input  1  serial data bit, MSB first
din_valid  input  1  din is sampled only on edges where this is 1
ch0  output  WIDTH  channel 0 word, registered
ch1  output  WIDTH  channel 1 word, registered
ch2  output  WIDTH  channel 2 word, registered
ch3  output  WIDTH  channel 3 word, registered
frame_valid  output  1  one-cycle pulse when ch0..ch3 update
locked  output  1  alignment confirmed by at least one repeated sync word

Behaviour:
Interface:
- One clock: clk.
- Reset is asynchronous and active-high: reset.
Reset:
- ch0..ch3 = 0, frame_valid = 0, locked = 0.
- State HUNT; internal sync shift register = 0, fill count = 0, miss count = 0.
- Reset takes effect immediately, mid-frame included. Any partial frame is discarded.
Bit acceptance:
- A bit is accepted only on an edge with din_valid = 1.
- din_valid = 0 freezes all counters and state.
Frame format:
- SYNC_WORD (8 bits), then ch0, ch1, ch2, ch3 (WIDTH bits each), all MSB first.
- Frame length is 8 + 4*WIDTH bits.
States:
- HUNT: shift each accepted bit into the 8-bit sync register; fill count saturates at 8.
  - Match when fill = 8, counting the current bit, and the register including that bit equals SYNC_WORD.
  - On match go to DATA, with slot = 0 and bit = 0.
- DATA: shift accepted bits into the slot assembly register.
  - After WIDTH bits, store the word in the slot buffer and increment slot.
  - On the edge that accepts the last bit of slot 3:
    - ch0..ch3 load simultaneously, with the current bit included in ch3.
    - frame_valid = 1 for exactly the following cycle.
    - State goes to CHECK.
  - Outputs hold between commits; they are never cleared except by reset.
- CHECK: accept 8 bits and compare them with SYNC_WORD on the 8th bit.
  - Match: miss = 0, locked = 1 (set at that edge), go to DATA.
  - Mismatch: miss = miss + 1.
    - If the new miss count equals MISS_LIMIT: locked = 0, miss = 0, fill = 0, go to HUNT.
    - Otherwise (flywheel): locked is unchanged, go to DATA, and the next frame is still decoded.
Boundary notes:
- The first frame after HUNT is committed with locked = 0; consumers qualify data with locked if required.
- frame_valid never asserts on two consecutive cycles; the minimum spacing is the frame length.
- The sync word is not searched inside DATA; false sync patterns in data are ignored while aligned.

Optional Feature:
Macro TDM_PARITY_EN.
- Defined:
  - One extra bit P follows slot 3. Even parity: XOR of all 4*WIDTH data bits and P must be 0.
  - The commit moves to the edge that accepts P.
  - On parity failure: no commit, no frame_valid, and the extra output parity_err (1 bit, reset 0) pulses for one cycle. State goes to CHECK either way.
  - Frame length is 9 + 4*WIDTH bits.
- Undefined:
  - No parity bit and no parity_err port; behaviour is exactly as above.

Test Plan:
1. After reset, send A5,11,22,33,44 continuously -> frame_valid pulse 1 cycle after the 40th bit edge; ch0..ch3 = 11,22,33,44; locked = 0.
2. Continue with A5,55,66,77,88 -> locked = 1 from the 8th sync-bit edge; second pulse; ch0..ch3 = 55,66,77,88.
3. Prefix with junk bits 1,0,1,1,0 then test 1's stream -> same outputs; no frame_valid before alignment.
4. Locked, one sync = A4 then a good A5 -> locked stays 1, both frames decoded, miss cleared. Two consecutive A4 -> locked = 0 at the 8th bit of the second bad sync; no frame_valid until a new A5 is found.
5. din_valid low for 5 cycles inside ch2 -> identical words; frame_valid delayed by exactly 5 cycles.
6. Assert reset mid-ch1, with ch0..ch3 previously 55..88 -> all outputs 0 immediately; after release, a full A5 frame is required before the next frame_valid.
With TDM_PARITY_EN: correct P -> commit. Flipped P -> parity_err pulse, ch0..ch3 unchanged.
